// File: rtl/ultrasound_fsm.sv
// ---------------------------------------------------------------------------
// ultrasound_fsm: TX fire -> init delay -> ADC acquire sequencer.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ultrasound_fsm #(
  parameter int ADC_SAMPLES_PER_ECHO_WIDTH = 32,
  parameter int ADC_INIT_DELAY_WIDTH       = 32
) (
  input  logic                                  CLK,
  input  logic                                  RESET,
  input  logic                                  START,
  input  logic [31:0]                           ADC_START_length,
  input  logic [ADC_INIT_DELAY_WIDTH-1:0]       ADC_INIT_DELAY,
  input  logic [ADC_SAMPLES_PER_ECHO_WIDTH-1:0] ADC_SAMPLES_PER_ECHO,
  output logic                                  TX_EN,
  output logic                                  FIFO_EN,
  output logic                                  DONE
);

  localparam int LEN_W = 32;
  localparam int DLY_W = ADC_INIT_DELAY_WIDTH;
  localparam int SMP_W = ADC_SAMPLES_PER_ECHO_WIDTH;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    TX     = 3'd1,
    DELAY  = 3'd2,
    ACQ    = 3'd3,
    FINISH = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [LEN_W-1:0]   r_len;
  logic [DLY_W-1:0]   r_dly;
  logic [SMP_W-1:0]   r_smp;
  logic [LEN_W-1:0]   r_tx_cnt;
  logic [DLY_W-1:0]   r_dly_cnt;
  logic [SMP_W-1:0]   r_acq_cnt;
  logic [LEN_W-1:0]   w_len;
  logic [DLY_W-1:0]   w_dly;
  logic [SMP_W-1:0]   w_smp;

  // In IDLE the live inputs drive the first-phase decision and counter load;
  // afterwards only the values captured at START are used.
  assign w_len = (r_state == IDLE) ? ADC_START_length     : r_len;
  assign w_dly = (r_state == IDLE) ? ADC_INIT_DELAY       : r_dly;
  assign w_smp = (r_state == IDLE) ? ADC_SAMPLES_PER_ECHO : r_smp;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (START) begin
          if (w_len != '0)      w_next = TX;
          else if (w_dly != '0) w_next = DELAY;
          else if (w_smp != '0) w_next = ACQ;
          else                  w_next = FINISH;
        end
      end
      TX: begin
        if (r_tx_cnt <= LEN_W'(1)) begin
          if (w_dly != '0)      w_next = DELAY;
          else if (w_smp != '0) w_next = ACQ;
          else                  w_next = FINISH;
        end
      end
      DELAY: begin
        if (r_dly_cnt <= DLY_W'(1)) begin
          if (w_smp != '0) w_next = ACQ;
          else             w_next = FINISH;
        end
      end
      ACQ: begin
        if (r_acq_cnt <= SMP_W'(1)) w_next = FINISH;
      end
      FINISH: begin
        if (!START) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Counters hold the remaining cycles of their phase: loaded on entry,
  // decremented while resident, so a full-scale value never wraps.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state   <= IDLE;
      r_len     <= '0;
      r_dly     <= '0;
      r_smp     <= '0;
      r_tx_cnt  <= '0;
      r_dly_cnt <= '0;
      r_acq_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && START) begin
        r_len <= ADC_START_length;
        r_dly <= ADC_INIT_DELAY;
        r_smp <= ADC_SAMPLES_PER_ECHO;
      end
      if (w_next == TX && r_state != TX)            r_tx_cnt  <= w_len;
      else if (r_state == TX)                       r_tx_cnt  <= r_tx_cnt - LEN_W'(1);
      if (w_next == DELAY && r_state != DELAY)      r_dly_cnt <= w_dly;
      else if (r_state == DELAY)                    r_dly_cnt <= r_dly_cnt - DLY_W'(1);
      if (w_next == ACQ && r_state != ACQ)          r_acq_cnt <= w_smp;
      else if (r_state == ACQ)                      r_acq_cnt <= r_acq_cnt - SMP_W'(1);
    end
  end

  assign TX_EN   = (r_state == TX);
  assign FIFO_EN = (r_state == ACQ);
  assign DONE    = (r_state == FINISH);

endmodule

`default_nettype wire

// File: tb/tb_ultrasound_fsm.sv
// ---------------------------------------------------------------------------
// tb_ultrasound_fsm: pulse scoreboard for the ultrasound sequencer.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ultrasound_fsm;

  localparam int DW = 5;
  localparam int SW = 4;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [31:0]   len   = '0;
  logic [DW-1:0] dly   = '0;
  logic [SW-1:0] smp   = '0;
  logic          tx_en;
  logic          fifo_en;
  logic          done;

  always #5 clk = ~clk;

  ultrasound_fsm #(
    .ADC_SAMPLES_PER_ECHO_WIDTH(SW),
    .ADC_INIT_DELAY_WIDTH      (DW)
  ) dut (
    .CLK                 (clk),
    .RESET               (rst_n),
    .START               (start),
    .ADC_START_length    (len),
    .ADC_INIT_DELAY      (dly),
    .ADC_SAMPLES_PER_ECHO(smp),
    .TX_EN               (tx_en),
    .FIFO_EN             (fifo_en),
    .DONE                (done)
  );

  typedef struct {
    int kind;
    int st;
    int ln;
  } pulse_t;

  pulse_t exp_q[$];
  string  names[3] = '{"tx_en", "fifo_en", "done"};
  int     cyc   = 0;
  int     n_cmp = 0;
  int     n_err = 0;
  int     rise[3];
  logic [2:0] prev = '0;
  logic [2:0] cur;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d", nm, act, req);
    end
  endtask

  task automatic check_pulse(input int kind, input int st, input int ln);
    pulse_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL unexpected_%s: pulse start %0d len %0d, required no pulse", names[kind], st, ln);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.st != st || e.ln != ln) begin
        n_err++;
        $display("FAIL pulse: got %s start %0d len %0d required %s start %0d len %0d",
                 names[kind], st, ln, names[e.kind], e.st, e.ln);
      end
    end
  endtask

  // Monitor: turns output levels into pulses and scores each one as it ends.
  always @(negedge clk) begin
    cur = {done, fifo_en, tx_en};
    n_cmp++;
    if ($countones(cur) > 1) begin
      n_err++;
      $display("FAIL exclusive: outputs %b required at most one high", cur);
    end
    for (int i = 0; i < 3; i++) begin
      if (cur[i] && !prev[i]) rise[i] = cyc;
      if (!cur[i] && prev[i]) check_pulse(i, rise[i], cyc - rise[i]);
    end
    prev = cur;
  end

  // START is raised at the negedge where cyc==k and dropped after 'hold'
  // negedges; mod_at>0 rewrites the delay input that many cycles in.
  task automatic run_seq(input int l, input int d, input int s, input int hold,
                         input int mod_at, input int mod_val);
    int k, f, dlen, fall;
    @(negedge clk);
    k     = cyc;
    len   = l;
    dly   = DW'(d);
    smp   = SW'(s);
    start = 1'b1;
    if (l > 0) exp_q.push_back('{kind: 0, st: k + 1, ln: l});
    if (s > 0) exp_q.push_back('{kind: 1, st: k + 1 + l + d, ln: s});
    f    = k + 1 + l + d + s;
    fall = (k + hold + 1 > f + 1) ? (k + hold + 1) : (f + 1);
    dlen = fall - f;
    exp_q.push_back('{kind: 2, st: f, ln: dlen});
    for (int t = 1; t <= fall - k + 3; t++) begin
      @(negedge clk);
      if (t == hold)   start = 1'b0;
      if (t == mod_at) dly   = DW'(mod_val);
    end
  endtask

  task automatic reset_during_acq();
    int k;
    @(negedge clk);
    k     = cyc;
    len   = 2;
    dly   = 1;
    smp   = 5;
    start = 1'b1;
    exp_q.push_back('{kind: 0, st: k + 1, ln: 2});
    exp_q.push_back('{kind: 1, st: k + 4, ln: 3});
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("fifo_en_before_reset", int'(fifo_en), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", int'({tx_en, fifo_en, done}), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("idle_after_reset", int'({tx_en, fifo_en, done}), 0);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_outputs", int'({tx_en, fifo_en, done}), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_outputs", int'({tx_en, fifo_en, done}), 0);

    run_seq(5, 10, 10, 25, 0, 0);   // nominal fire/acquire
    run_seq(0, 0, 3, 10, 0, 0);     // TX and DELAY skipped
    run_seq(1, 1, 1, 25, 0, 0);     // START held through FINISH
    run_seq(2, 2, 2, 3, 0, 0);      // retrigger after START dropped
    run_seq(4, 10, 2, 2, 2, 2);     // delay input changed during TX
    run_seq(2, 1, 2, 1, 0, 0);      // single-cycle START
    run_seq(0, 0, 0, 1, 0, 0);      // straight to FINISH
    run_seq(0, 0, 0, 2, 0, 0);
    run_seq(3, 0, 0, 1, 0, 0);
    run_seq(1, 31, 15, 1, 0, 0);    // full-scale delay and sample counts
    reset_during_acq();

    repeat (3) @(negedge clk);
    chk("expected_pulses_left", exp_q.size(), 0);
    chk("outputs_quiet_at_end", int'(prev), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, required bench completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
